// File: rtl/wrr_arbiter_ack.sv
// Weighted round-robin arbiter with registered one-hot grant, binary grant index,
// per-client credit counters and an optional grant/acknowledge hold mode.
module wrr_arbiter_ack #(
    parameter int unsigned CLIENTS      = 4,
    parameter int unsigned MAX_LEVELS   = 16,
    parameter int unsigned WAIT_GNT_ACK = 0,
    localparam int unsigned IW          = $clog2(CLIENTS),
    localparam int unsigned WW          = $clog2(MAX_LEVELS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  block_arb,
    input  logic [CLIENTS*WW-1:0] cfg_weight,
    input  logic [CLIENTS-1:0]    req,
    input  logic [CLIENTS-1:0]    grant_ack,
    output logic                  grant_valid,
    output logic [CLIENTS-1:0]    grant,
    output logic [IW-1:0]         grant_id
);

    logic [WW-1:0]      weight   [CLIENTS];
    logic [WW-1:0]      used_q   [CLIENTS];
    logic [WW-1:0]      used_d   [CLIENTS];
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      grant_id_q, grant_id_d;
    logic [CLIENTS-1:0] grant_q, grant_d;
    logic               grant_valid_q, grant_valid_d;

    logic [CLIENTS-1:0] enabled, eligible, cand;
    logic               replenish;
    logic               found;
    logic [IW-1:0]      winner;
    logic               ack_hit, upd;

    // Candidate set: eligible requesters, or all enabled requesters when credits are exhausted.
    always_comb begin
        enabled  = '0;
        eligible = '0;
        for (int unsigned i = 0; i < CLIENTS; i++) begin
            weight[i]   = cfg_weight[i*WW +: WW];
            enabled[i]  = (weight[i] != '0);
            eligible[i] = enabled[i] && (used_q[i] < weight[i]);
        end
        // Replenish only if some enabled client is actually asking; otherwise keep credits.
        replenish = ((req & eligible) == '0) && ((req & enabled) != '0);
        cand      = replenish ? (req & enabled) : (req & eligible);
    end

    // Round-robin search starting one past the last granted client, wrapping upward.
    always_comb begin
        logic [IW-1:0] idx;
        idx    = '0;
        found  = 1'b0;
        winner = '0;
        for (int unsigned k = 1; k <= CLIENTS; k++) begin
            idx = IW'((32'(ptr_q) + k) % CLIENTS);
            if (!found && cand[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // Re-arbitrate when idle, every cycle in single-cycle mode, or when the held grant is acked.
    always_comb begin
        ack_hit = (WAIT_GNT_ACK != 0) ? |(grant_q & grant_ack) : 1'b1;
        upd     = !grant_valid_q || ack_hit;
    end

    // Next-state for grant registers, pointer and credit counters; credit is charged at load.
    always_comb begin
        grant_d       = grant_q;
        grant_id_d    = grant_id_q;
        grant_valid_d = grant_valid_q;
        ptr_d         = ptr_q;
        for (int unsigned i = 0; i < CLIENTS; i++) begin
            used_d[i] = used_q[i];
        end
        if (upd) begin
            if (!block_arb && found) begin
                grant_d         = '0;
                grant_d[winner] = 1'b1;
                grant_id_d      = winner;
                grant_valid_d   = 1'b1;
                ptr_d           = winner;
                if (replenish) begin
                    for (int unsigned i = 0; i < CLIENTS; i++) begin
                        used_d[i] = '0;
                    end
                    used_d[winner] = WW'(1);
                end else begin
                    used_d[winner] = used_q[winner] + WW'(1);
                end
            end else begin
                // Idle or blocked: drop the grant but leave pointer and credits untouched.
                grant_d       = '0;
                grant_id_d    = '0;
                grant_valid_d = 1'b0;
            end
        end
    end

    // State registers; reset leaves the pointer at the last client so client 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q       <= '0;
            grant_id_q    <= '0;
            grant_valid_q <= 1'b0;
            ptr_q         <= IW'(CLIENTS - 1);
            for (int unsigned i = 0; i < CLIENTS; i++) begin
                used_q[i] <= '0;
            end
        end else begin
            grant_q       <= grant_d;
            grant_id_q    <= grant_id_d;
            grant_valid_q <= grant_valid_d;
            ptr_q         <= ptr_d;
            for (int unsigned i = 0; i < CLIENTS; i++) begin
                used_q[i] <= used_d[i];
            end
        end
    end

    assign grant       = grant_q;
    assign grant_id    = grant_id_q;
    assign grant_valid = grant_valid_q;

endmodule

// File: tb/tb_wrr_arbiter_ack.sv
// Bench for wrr_arbiter_ack: one instance per grant mode sharing stimulus, checked
// against a per-mode credit/round-robin model plus directed expectations.
module tb_wrr_arbiter_ack;

    localparam int N  = 4;
    localparam int WW = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            block_arb = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    grant_ack = '0;
    logic [N*WW-1:0] cfg_weight;
    int              w [N];

    logic [N-1:0] g0, g1;
    logic [1:0]   id0, id1;
    logic         v0, v1;

    int checks = 0;
    int errors = 0;

    // Model state, index 0 = single-cycle grant mode, 1 = ack-hold mode
    int m_used  [2][N];
    int m_ptr   [2];
    int m_id    [2];
    bit m_valid [2];

    int wseq [11] = '{0, 1, 2, 3, 1, 2, 3, 2, 3, 3, 0};

    always #5 clk = ~clk;

    always_comb begin
        cfg_weight = '0;
        for (int i = 0; i < N; i++) cfg_weight[i*WW +: WW] = WW'(w[i]);
    end

    wrr_arbiter_ack #(.CLIENTS(4), .MAX_LEVELS(16), .WAIT_GNT_ACK(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .block_arb(block_arb), .cfg_weight(cfg_weight),
        .req(req), .grant_ack(grant_ack), .grant_valid(v0), .grant(g0), .grant_id(id0)
    );

    wrr_arbiter_ack #(.CLIENTS(4), .MAX_LEVELS(16), .WAIT_GNT_ACK(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .block_arb(block_arb), .cfg_weight(cfg_weight),
        .req(req), .grant_ack(grant_ack), .grant_valid(v1), .grant(g1), .grant_id(id1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_w(input int a, input int b, input int c, input int d);
        w[0] = a; w[1] = b; w[2] = c; w[3] = d;
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < N; i++) m_used[m][i] = 0;
            m_ptr[m]   = N - 1;
            m_id[m]    = 0;
            m_valid[m] = 1'b0;
        end
    endtask

    // One arbitration step from the rules: credits, replenish, rotating priority, hold.
    task automatic model_step(input int m);
        bit any_elig, repl;
        int win, i;
        if (m_valid[m] && m == 1 && !grant_ack[m_id[m]]) return;
        any_elig = 1'b0;
        repl     = 1'b0;
        for (int c = 0; c < N; c++)
            if (req[c] && w[c] != 0 && m_used[m][c] < w[c]) any_elig = 1'b1;
        if (!any_elig)
            for (int c = 0; c < N; c++) if (req[c] && w[c] != 0) repl = 1'b1;
        win = -1;
        for (int k = 1; k <= N; k++) begin
            i = (m_ptr[m] + k) % N;
            if (win < 0 && req[i] && w[i] != 0 && (repl || m_used[m][i] < w[i])) win = i;
        end
        if (!block_arb && win >= 0) begin
            if (repl) for (int c = 0; c < N; c++) m_used[m][c] = 0;
            m_used[m][win]++;
            m_ptr[m]   = win;
            m_id[m]    = win;
            m_valid[m] = 1'b1;
        end else begin
            m_id[m]    = 0;
            m_valid[m] = 1'b0;
        end
    endtask

    task automatic compare_model();
        int eg;
        for (int m = 0; m < 2; m++) begin
            eg = m_valid[m] ? (1 << m_id[m]) : 0;
            if (m == 0) begin
                check("m0_grant", g0, eg);
                check("m0_id", id0, m_id[0]);
                check("m0_valid", v0, m_valid[0]);
            end else begin
                check("m1_grant", g1, eg);
                check("m1_id", id1, m_id[1]);
                check("m1_valid", v1, m_valid[1]);
            end
        end
    endtask

    // Inputs are set at negedge; model advances at posedge; outputs sampled at next negedge.
    task automatic step();
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        compare_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req       = '0;
        grant_ack = '0;
        block_arb = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        set_w(1, 2, 3, 4);
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_grant0", g0, 0);
        check("rst_grant1", g1, 0);
        check("rst_valid0", v0, 0);
        check("rst_valid1", v1, 0);
        check("rst_id0", id0, 0);
        rst_n = 1'b1;

        // Weighted sequence in single-cycle mode
        req = 4'hF;
        for (int k = 0; k < 11; k++) begin
            step();
            check("wseq_id", id0, wseq[k]);
            check("wseq_valid", v0, 1);
        end

        // Ack hold: grant stays through req drop until acked, next grant follows immediately
        do_reset();
        set_w(2, 2, 2, 2);
        req = 4'b0011;
        step();
        check("ack_hold1", g1, 4'b0001);
        req = 4'b0010;
        step();
        check("ack_hold2", g1, 4'b0001);
        step();
        check("ack_hold3", g1, 4'b0001);
        grant_ack = 4'b0001;
        step();
        check("ack_next", g1, 4'b0010);
        grant_ack = '0;

        // Disabled client never granted, no replenish
        do_reset();
        set_w(0, 1, 1, 1);
        req = 4'b0001;
        repeat (4) begin
            step();
            check("dis_valid0", v0, 0);
            check("dis_valid1", v1, 0);
        end

        // Single requester: replenish every cycle
        do_reset();
        set_w(1, 1, 1, 1);
        req = 4'b0100;
        repeat (4) begin
            step();
            check("single_grant", g0, 4'b0100);
            check("single_id", id0, 2);
        end

        // block_arb in single-cycle mode, resume from saved pointer
        do_reset();
        set_w(4, 4, 4, 4);
        req = 4'hF;
        step();
        check("blk_first", id0, 0);
        step();
        check("blk_second", id0, 1);
        block_arb = 1'b1;
        step();
        check("blk_off1", g0, 0);
        step();
        check("blk_off2", g0, 0);
        block_arb = 1'b0;
        step();
        check("blk_resume", g0, 4'b0100);

        // Asynchronous reset while an ack-mode grant is held
        do_reset();
        set_w(1, 1, 1, 1);
        req = 4'b1000;
        step();
        check("mid_pre", g1, 4'b1000);
        #2 rst_n = 1'b0;
        #1;
        check("mid_grant", g1, 0);
        check("mid_valid", v1, 0);
        check("mid_id", id1, 0);
        model_reset();
        req = 4'hF;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("mid_after0", g0, 4'b0001);
        check("mid_after1", g1, 4'b0001);

        // Randomized traffic with live weight changes, blocking and stray acks
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (cyc % 60 == 0)
                for (int i = 0; i < N; i++) w[i] = $urandom_range(0, 6);
            if ($urandom_range(0, 19) == 0) w[$urandom_range(0, 3)] = $urandom_range(0, 6);
            req       = N'($urandom);
            grant_ack = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            block_arb = ($urandom_range(0, 9) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
